// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared types and helpers for the divider arbiter
package div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BUSY   = 3'd2,
        RESP   = 3'd3,
        DRAIN  = 3'd4
    } arb_state_t;

    // Watchdog counter width; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (enable && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one multi-cycle signed divider
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DIVIDEND_WIDTH-1:0]           rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]            rsp_remainder,
    output logic                                rsp_overflow,
    output logic                                rsp_timeout,
    output logic                                div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]            div_remainder,
    input  logic                                div_valid_out,
    input  logic                                div_overflow,
    output logic                                busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    arb_state_t                 state;
    logic [IDX_W-1:0]           ptr;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           arb_idx;
    logic [NUM_REQ-1:0]         arb_grant;
    logic [NUM_REQ-1:0]         grant_oh;
    logic [DIVIDEND_WIDTH-1:0]  op_dividend;
    logic [DIVISOR_WIDTH-1:0]   op_divisor;
    logic [CNT_W-1:0]           wd_cnt;
    logic                       sticky_ov;
    logic                       handshake;

    // Ready is gated by reset too, so every output reads zero while reset is held.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    ((state == IDLE) && !reset),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready    = arb_grant;
    assign handshake    = |(req_valid & arb_grant);
    assign busy         = (state != IDLE);
    assign div_valid_in = (state == LAUNCH);
    assign div_dividend = op_dividend;
    assign div_divisor  = op_divisor;
    assign grant_oh     = NUM_REQ'(1) << grant_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= IDX_W'(NUM_REQ - 1);
            grant_idx     <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            wd_cnt        <= '0;
            sticky_ov     <= 1'b0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        op_dividend <= req_dividend[arb_idx*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                        op_divisor  <= req_divisor[arb_idx*DIVISOR_WIDTH +: DIVISOR_WIDTH];
                        grant_idx   <= arb_idx;
                        ptr         <= arb_idx;
                        sticky_ov   <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: state <= BUSY;
                BUSY: begin
                    if (div_valid_out) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_overflow  <= sticky_ov | div_overflow;
                        rsp_timeout   <= 1'b0;
                        rsp_valid     <= grant_oh;
                        state         <= RESP;
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_overflow  <= sticky_ov | div_overflow;
                        rsp_timeout   <= 1'b1;
                        rsp_valid     <= grant_oh;
                        state         <= DRAIN;
                    end else begin
                        wd_cnt    <= wd_cnt + 1'b1;
                        sticky_ov <= sticky_ov | div_overflow;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                // The late divider result is swallowed; the requester already got its timeout.
                DRAIN: begin
                    rsp_valid <= '0;
                    if (div_valid_out) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized self-checking bench for div_arbiter
module tb_div_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int VW = 32;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_dividend;
    logic [N*VW-1:0] req_divisor;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_quotient;
    logic [VW-1:0]   rsp_remainder;
    logic            rsp_overflow;
    logic            rsp_timeout;
    logic            div_valid_in;
    logic [DW-1:0]   div_dividend;
    logic [VW-1:0]   div_divisor;
    logic [DW-1:0]   div_quotient;
    logic [VW-1:0]   div_remainder;
    logic            div_valid_out;
    logic            div_overflow;
    logic            busy;

    int vec  = 0;
    int miss = 0;
    int ptr_m;
    int lat_cfg = 4;
    int pend;

    logic [DW-1:0] a_arr [N];
    logic [VW-1:0] b_arr [N];

    always #5 clk = ~clk;

    div_arbiter #(
        .NUM_REQ        (N),
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (VW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_overflow  (rsp_overflow),
        .rsp_timeout   (rsp_timeout),
        .div_valid_in  (div_valid_in),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_valid_out (div_valid_out),
        .div_overflow  (div_overflow),
        .busy          (busy)
    );

    function automatic logic [63:0] ref_q(input logic [63:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, t;
        if (b == 32'd0) return a;
        sa = a;
        sb = {{32{b[31]}}, b};
        t  = sa / sb;
        return t;
    endfunction

    function automatic logic [31:0] ref_r(input logic [63:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, t;
        if (b == 32'd0) return a[31:0];
        sa = a;
        sb = {{32{b[31]}}, b};
        t  = sa % sb;
        return t[31:0];
    endfunction

    // Divider stub: result is computed from the live operand bus when it completes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend         <= 0;
            div_overflow <= 1'b0;
        end else if (div_valid_in) begin
            pend         <= lat_cfg;
            div_overflow <= (div_divisor == 32'd0);
        end else begin
            if (pend > 0) pend <= pend - 1;
            div_overflow <= 1'b0;
        end
    end

    assign div_valid_out = (pend == 1);
    assign div_quotient  = ref_q(div_dividend, div_divisor);
    assign div_remainder = ref_r(div_dividend, div_divisor);

    function automatic int model_grant(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr_m + k) % N;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_dividend[i*DW +: DW] = a_arr[i];
            req_divisor[i*VW +: VW]  = b_arr[i];
        end
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = {$urandom, $urandom};
            b_arr[i] = $urandom;
        end
        drive_ops();
    endtask

    task automatic serve_one(input logic [N-1:0] mask, input int lat, input bit drop,
                             output int g, output logic [63:0] q, output logic [31:0] r,
                             output logic ov);
        int n;
        bit seen;
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] ea;
        logic [VW-1:0] eb;
        lat_cfg = lat;
        g  = model_grant(mask);
        exp_oh = N'(1) << g;
        ea = a_arr[g];
        eb = b_arr[g];
        @(negedge clk);
        req_valid = mask;
        drive_ops();
        #1;
        vec++;
        if (req_ready !== exp_oh) begin
            miss++;
            $display("FAIL grant_ready: req_ready=%b expected %b", req_ready, exp_oh);
        end
        @(posedge clk);
        ptr_m = g;
        @(negedge clk);
        if (drop) begin
            req_valid = '0;
            scramble_ops();
        end
        vec++;
        if (div_valid_in !== 1'b1 || busy !== 1'b1) begin
            miss++;
            $display("FAIL launch: div_valid_in=%b busy=%b expected 1 1", div_valid_in, busy);
        end
        vec++;
        if (div_dividend !== ea || div_divisor !== eb) begin
            miss++;
            $display("FAIL operands: dividend=%h divisor=%h expected %h %h", div_dividend, div_divisor, ea, eb);
        end
        n = 0;
        seen = 0;
        while (!seen && n < lat + 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid !== '0) seen = 1;
        end
        vec++;
        if (!seen || n != lat + 1) begin
            miss++;
            $display("FAIL rsp_latency: response after %0d cycles (seen=%0d) expected %0d", n, seen, lat + 1);
        end
        vec++;
        if (rsp_valid !== exp_oh) begin
            miss++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_oh);
        end
        vec++;
        if (rsp_quotient !== ref_q(ea, eb) || rsp_remainder !== ref_r(ea, eb)) begin
            miss++;
            $display("FAIL rsp_result: q=%h r=%h expected %h %h", rsp_quotient, rsp_remainder, ref_q(ea, eb), ref_r(ea, eb));
        end
        vec++;
        if (rsp_overflow !== (eb == 32'd0) || rsp_timeout !== 1'b0) begin
            miss++;
            $display("FAIL rsp_flags: overflow=%b timeout=%b expected %b 0", rsp_overflow, rsp_timeout, (eb == 32'd0));
        end
        q  = rsp_quotient;
        r  = rsp_remainder;
        ov = rsp_overflow;
    endtask

    task automatic test_reset();
        #1;
        vec++;
        if ({req_ready, rsp_valid, busy, div_valid_in, div_dividend, div_divisor,
             rsp_quotient, rsp_remainder, rsp_overflow, rsp_timeout} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: ready=%b rsp=%b busy=%b dvi=%b dd=%h dv=%h expected all zero",
                     req_ready, rsp_valid, busy, div_valid_in, div_dividend, div_divisor);
        end
        @(negedge clk);
        reset = 1'b0;
        ptr_m = N - 1;
    endtask

    task automatic test_single();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        a_arr[1] = 64'd100;
        b_arr[1] = 32'd7;
        serve_one(4'b0010, 5, 1, g, q, r, ov);
        vec++;
        if (q !== 64'd14 || r !== 32'd2 || ov !== 1'b0) begin
            miss++;
            $display("FAIL single_100_div_7: q=%0d r=%0d ov=%b expected 14 2 0", q, r, ov);
        end
    endtask

    task automatic test_signed();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        a_arr[0] = 64'hFFFF_FFFF_FFFF_FF9C;
        b_arr[0] = 32'd7;
        serve_one(4'b0001, 3, 1, g, q, r, ov);
        vec++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFF2 || r !== 32'hFFFF_FFFE) begin
            miss++;
            $display("FAIL signed_div: q=%h r=%h expected fffffffffffffff2 fffffffe", q, r);
        end
    endtask

    task automatic test_div_zero();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        a_arr[2] = 64'd55;
        b_arr[2] = 32'd0;
        serve_one(4'b0100, 4, 1, g, q, r, ov);
        vec++;
        if (ov !== 1'b1 || q !== 64'd55) begin
            miss++;
            $display("FAIL div_zero: ov=%b q=%0d expected 1 55", ov, q);
        end
    endtask

    task automatic test_fairness();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        int order [5];
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ptr_m = N - 1;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 64'(1000 * (i + 1) + i);
            b_arr[i] = 32'(i + 3);
        end
        for (int k = 0; k < 5; k++) begin
            serve_one(4'hF, 2 + k, 0, g, q, r, ov);
            order[k] = g;
        end
        req_valid = '0;
        vec++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            miss++;
            $display("FAIL fairness_order: %0d %0d %0d %0d %0d expected 0 1 2 3 0",
                     order[0], order[1], order[2], order[3], order[4]);
        end
    endtask

    task automatic test_random();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                a_arr[i] = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       b_arr[i] = 32'd0;
                    1:       b_arr[i] = 32'($urandom_range(1, 50));
                    default: b_arr[i] = $urandom;
                endcase
                if (b_arr[i] == 32'hFFFF_FFFF) b_arr[i] = 32'd3;
            end
            serve_one(4'($urandom_range(1, 15)), $urandom_range(1, 12), 1, g, q, r, ov);
        end
    endtask

    task automatic test_timeout();
        int n, m;
        bit seen, extra, busy_drop;
        logic [N-1:0] exp_oh;
        int g;
        lat_cfg = 40;
        a_arr[3] = 64'd999;
        b_arr[3] = 32'd9;
        g = model_grant(4'b1000);
        exp_oh = N'(1) << g;
        @(negedge clk);
        req_valid = 4'b1000;
        drive_ops();
        @(posedge clk);
        ptr_m = g;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (rsp_valid !== '0) seen = 1;
        end
        vec++;
        if (!seen || n != TO + 1) begin
            miss++;
            $display("FAIL timeout_latency: response after %0d cycles (seen=%0d) expected %0d", n, seen, TO + 1);
        end
        vec++;
        if (rsp_valid !== exp_oh || rsp_timeout !== 1'b1 || rsp_quotient !== '0 || rsp_remainder !== '0) begin
            miss++;
            $display("FAIL timeout_rsp: valid=%b to=%b q=%h r=%h expected %b 1 0 0",
                     rsp_valid, rsp_timeout, rsp_quotient, rsp_remainder, exp_oh);
        end
        m = n;
        extra = 0;
        busy_drop = 0;
        while (div_valid_out !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
            if (rsp_valid !== '0) extra = 1;
            if (busy !== 1'b1) busy_drop = 1;
        end
        vec++;
        if (extra || busy_drop || m != 40) begin
            miss++;
            $display("FAIL drain: extra_rsp=%0d busy_dropped=%0d done_at=%0d expected 0 0 40", extra, busy_drop, m);
        end
        @(negedge clk);
        vec++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            miss++;
            $display("FAIL drain_exit: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int g; logic [63:0] q; logic [31:0] r; logic ov;
        bit extra;
        a_arr[2] = 64'd77;
        b_arr[2] = 32'd5;
        serve_one(4'b0100, 3, 1, g, q, r, ov);
        lat_cfg = 30;
        a_arr[2] = 64'd12345;
        b_arr[2] = 32'd11;
        @(negedge clk);
        req_valid = 4'b0100;
        drive_ops();
        @(posedge clk);
        ptr_m = 2;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        vec++;
        if ({req_ready, rsp_valid, busy, div_valid_in, div_dividend, div_divisor} !== '0) begin
            miss++;
            $display("FAIL reset_mid_outputs: ready=%b rsp=%b busy=%b dvi=%b dd=%h dv=%h expected all zero",
                     req_ready, rsp_valid, busy, div_valid_in, div_dividend, div_divisor);
        end
        ptr_m = N - 1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) extra = 1;
        end
        vec++;
        if (extra) begin
            miss++;
            $display("FAIL reset_abandon: response or busy seen after reset, expected none");
        end
        a_arr[1] = 64'd600;
        b_arr[1] = 32'd6;
        a_arr[3] = 64'd900;
        b_arr[3] = 32'd9;
        serve_one(4'b1010, 2, 1, g, q, r, ov);
        vec++;
        if (q !== 64'd100) begin
            miss++;
            $display("FAIL reset_pointer: quotient %0d expected 100 from requester 1", q);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        test_reset();
        test_single();
        test_signed();
        test_div_zero();
        test_fairness();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
